gray_counter: RTL
=================

GRAY_COUNTER -- requirements
Module: gray_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning counter width in bits (legal range 2..16).
REQ-002 SHALL have port clk  input  1  rising-edge clock; one clock domain only.
REQ-003 SHALL have port rst  input  1  synchronous reset, active-high.
REQ-004 SHALL have port en  input  1  count enable; one step per cycle while high.
REQ-005 SHALL have port up_dn  input  1  direction; 1 = increment, 0 = decrement.
REQ-006 SHALL have port load  input  1  synchronous load strobe (present only with GRAY_LOAD_EN).
REQ-007 SHALL have port load_bin  input  WIDTH  binary value to load (present only with GRAY_LOAD_EN).
REQ-008 SHALL have port gray_out  output  WIDTH  registered Gray code of the current count; feeds gray_to_binary downstream.
REQ-009 SHALL have port bin_out  output  WIDTH  registered binary count, same cycle as gray_out.
REQ-010 SHALL have port tc  output  1  registered one-cycle terminal-count (wrap) pulse.

Function
REQ-011 SHALL hold the count in a WIDTH-bit binary register; gray_out SHALL equal bin_out ^ (bin_out >> 1) in every cycle.
REQ-012 SHALL, on a clk edge with en=1, up_dn=1, set bin_out to bin_out+1 modulo 2^WIDTH; outputs visible the next cycle (latency 1).
REQ-013 SHALL, on a clk edge with en=1, up_dn=0, set bin_out to bin_out-1 modulo 2^WIDTH.
REQ-014 SHALL hold bin_out, gray_out unchanged when en=0 (and load=0).
REQ-015 SHALL change exactly one gray_out bit per enabled step, including at wrap-around.
REQ-016 SHALL assert tc for exactly one cycle after an enabled step that wraps: up from 2^WIDTH-1 to 0, or down from 0 to 2^WIDTH-1; tc=0 in all other cycles.
REQ-017 SHALL, with en held high across consecutive wraps, pulse tc once per wrap (every 2^WIDTH cycles).
REQ-018 SHALL give load priority over en: load=1 sets bin_out=load_bin and gray_out=Gray(load_bin) next cycle, tc=0, regardless of en/up_dn.
REQ-019 SHALL not assert tc on a load, even when loading 0 or 2^WIDTH-1.
REQ-020 SHALL treat up_dn changes as taking effect on the same edge at which they are sampled; no extra dead cycle.

Reset
REQ-021 SHALL, on a clk edge with rst=1, set bin_out=0, gray_out=0, tc=0.
REQ-022 SHALL give rst priority over load and en; a reset mid-count discards the step in flight.
REQ-023 SHALL resume counting from 0 on the first edge after rst deasserts if en=1.

Configuration
REQ-024 SHALL, with macro GRAY_LOAD_EN defined, include load/load_bin ports and REQ-018/019 behaviour.
REQ-025 SHALL, without GRAY_LOAD_EN, omit load/load_bin ports entirely; all other behaviour unchanged.

Structure
REQ-026 SHALL take the default WIDTH constant and a bin2gray function (b ^ (b>>1)) from shared package gray_pkg, for reuse by gray_to_binary benches.
REQ-027 SHALL instantiate one combinational sub-module gray_enc (binary in, Gray out) to form the next-state Gray value, registered alongside the binary next state.

Verification (WIDTH=4)
REQ-028 SHALL cover: rst=1 one cycle -> bin_out=0, gray_out=4'b0000, tc=0.
REQ-029 SHALL cover: en=1, up_dn=1 for 16 cycles from 0 -> gray_out sequence 0000,0001,0011,0010,...,1000 then 0000; tc=1 only in the cycle showing 0000 after 1000.
REQ-030 SHALL cover: en=1, up_dn=0 from 0 -> next gray_out=4'b1000, bin_out=15, tc=1 for one cycle.
REQ-031 SHALL cover: count at bin_out=5, en=0 for 3 cycles -> gray_out stays 4'b0111, tc=0.
REQ-032 SHALL cover (GRAY_LOAD_EN): load=1, load_bin=4'd15, en=1 -> next bin_out=15, gray_out=4'b1000, tc=0; next up step -> gray_out=0000, tc=1.
REQ-033 SHALL cover: rst=1 asserted at bin_out=9 with en=1, load=1 -> next cycle bin_out=0, gray_out=0, tc=0; gray_out feeding gray_to_binary reproduces bin_out every cycle.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared Gray-code definitions for the Gray counter and the gray_to_binary benches.
// The default counter width, the widest supported width and the binary-to-Gray
// mapping are defined here once.
package gray_pkg;

    localparam int DEFAULT_WIDTH  = 4;
    localparam int GRAY_MAX_WIDTH = 16;

    // Count direction as sampled from the up_dn pin.
    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    // Binary to reflected Gray code at the widest supported width. Narrower
    // callers zero-extend their operand and keep the low bits of the result.
    // Zero upper bits cannot disturb the low bits.
    function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(input logic [GRAY_MAX_WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray_enc.sv
// Combinational binary-to-Gray encoder of parameterised width.
// The mapping comes from gray_pkg::bin2gray.
module gray_enc
    import gray_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    // Widen to the package function width, encode, then keep the low WIDTH bits.
    assign gray = WIDTH'(bin2gray(GRAY_MAX_WIDTH'(bin)));

endmodule

// File: rtl/gray_counter.sv
// Up/down Gray-code counter with registered binary count, Gray count and wrap pulse.
// WIDTH must be in the range 2..16.
// Optional feature macro: GRAY_LOAD_EN adds a synchronous load (load/load_bin).
// The load has priority over counting and never produces a tc pulse.
module gray_counter
    import gray_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
`ifdef GRAY_LOAD_EN
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
`endif
    output logic [WIDTH-1:0] gray_out,
    output logic [WIDTH-1:0] bin_out,
    output logic             tc
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] gray_q;
    logic             tc_q;

    logic [WIDTH-1:0] bin_next;
    logic [WIDTH-1:0] gray_next;
    logic             wrap_next;
    dir_e             dir;

    assign dir = dir_e'(up_dn);

    // Compute the next binary count and whether this step wraps.
    // A load, when built in, overrides the step and suppresses the wrap flag.
    always_comb begin
        bin_next  = bin_q;
        wrap_next = 1'b0;
        if (en) begin
            if (dir == DIR_UP) begin
                bin_next  = bin_q + ONE;
                wrap_next = (bin_q == ALL_ONES);
            end else begin
                bin_next  = bin_q - ONE;
                wrap_next = (bin_q == '0);
            end
        end
`ifdef GRAY_LOAD_EN
        if (load) begin
            bin_next  = load_bin;
            wrap_next = 1'b0;
        end
`endif
    end

    // The Gray form of the next count is registered alongside the binary count.
    // gray_out and bin_out therefore always describe the same count.
    gray_enc #(
        .WIDTH(WIDTH)
    ) u_gray_enc (
        .bin  (bin_next),
        .gray (gray_next)
    );

    // State register. A synchronous reset wins over load and count.
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q  <= '0;
            gray_q <= '0;
            tc_q   <= 1'b0;
        end else begin
            bin_q  <= bin_next;
            gray_q <= gray_next;
            tc_q   <= wrap_next;
        end
    end

    assign bin_out  = bin_q;
    assign gray_out = gray_q;
    assign tc       = tc_q;

endmodule
